serial_alu_sequencer: RTL and testbench
=======================================

Name: serial_alu_sequencer

Overview:
Bit-serial execution stage that drives the register file's two scan ports. It accepts one ALU operation per handshake and scans the destination register (port 1) and source register (port 2) NSHIFT bits per cycle, least significant first. It computes the result with a carry chained across cycles, writes it back through port 1's scan_in, and holds the resulting flags. The flags feed the register file's flags input for special-register reads.

Parameters:
REG_BITS, 8, bits per register
NSHIFT, 2, bits scanned per cycle
LOG2_NR, 4, register index width (general registers 0-7, special registers 8-11)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  operation request
req_ready  out  1  high only in IDLE; transfer occurs on req_valid && req_ready
op  in  3  0 MOV, 1 ADD, 2 ADC, 3 SUB, 4 CMP, 5 AND, 6 OR, 7 XOR
wide  in  1  0: 8-bit op; 1: 16-bit op on an even/odd register pair (even register = low byte)
dst  in  LOG2_NR  destination / first operand register
src  in  LOG2_NR  source / second operand register
bit_index  out  3  scan step within the operation
reg_index  out  LOG2_NR  port 1 index
reg_index2  out  LOG2_NR  port 2 index
do_scan  out  1  port 1 scan enable
do_scan2  out  1  port 2 scan enable
scan_in  out  NSHIFT  port 1 write data
scan_in2  out  NSHIFT  port 2 write data
scan_out  in  NSHIFT  port 1 read data
scan_out2  in  NSHIFT  port 2 read data
flags  out  4  {V,S,C,Z}; bit 0 = Z, bit 1 = C, bit 2 = S, bit 3 = V
done  out  1  one-cycle pulse after the operation completes

Behaviour:
- States: IDLE, RUN, DONE. Reset: state IDLE, step counter 0, carry 0, flags 4'b0000, done 0, all scan enables 0.
- IDLE:
  - req_ready = 1.
  - On transfer, latch op, wide, dst and src; go to RUN with counter k = 0.
- RUN:
  - N = 4 steps (wide = 0) or 8 steps (wide = 1); k increments every cycle.
  - After step N-1, go to DONE.
  - bit_index = k.
  - reg_index = wide ? {dst[3:1], k[2]} : dst; reg_index2 is formed the same way from src.
  - do_scan = do_scan2 = 1 for every RUN cycle; both are 0 in IDLE and DONE.
- Port 1 write data:
  - scan_in = result bits for MOV, ADD, ADC, SUB, AND, OR, XOR.
  - scan_in = scan_out for CMP, so dst rotates back unchanged.
- Port 2 write data: scan_in2 = scan_out2 always, so src is preserved.
  - When dst == src, the register file prefers port 1. The result is still correct because both ports read identical bits.
- Operands: a = scan_out (dst), b = scan_out2 (src).
- Arithmetic: one NSHIFT-bit add per cycle, a + b' + c, with carry register c.
  - b' = b for ADD/ADC; b' = ~b for SUB/CMP.
  - Initial c: ADD 0, ADC flags.C, SUB/CMP 1.
  - c updates every step with the carry out of the NSHIFT-bit slice.
  - C after SUB/CMP is 1 when there is no borrow.
- Logic and move: AND/OR/XOR are bitwise on a and b; MOV result = b.
- Flags:
  - Z accumulates across steps (1 only if every result slice is 0).
  - On the last step:
    - S = result MSB.
    - C = final carry out.
    - V = carry into MSB XOR carry out of MSB.
  - AND/OR/XOR: C = 0, V = 0.
  - MOV leaves all flags unchanged.
  - Flags register updates on the clock edge ending step N-1.
- DONE: done = 1 for exactly one cycle, req_ready = 0, then go to IDLE.
- Latency: transfer at edge t → RUN cycles t+1 .. t+N → done at t+N+1 → req_ready at t+N+2. Sustained throughput is one op per N+2 cycles.
- Reset mid-operation: immediate return to reset state.
  - Partially rotated registers are left as-is; this is accepted by design.
  - No done pulse is issued.
- Restrictions:
  - wide = 1 requires dst[3] = src[3] = 0.
  - Special registers (8-11) are allowed only with wide = 0. Register 9 reads as constant 1, giving immediate-one operations.
  - req_valid and the request fields are ignored outside IDLE.

Test Plan:
- r1=0x7F, r2=0x01, ADD dst=1 src=2 → r1=0x80, r2=0x01, flags Z0 C0 S1 V1; done 5 cycles after transfer.
- r3=0x05, r4=0x05, SUB dst=3 src=4 → r3=0x00, flags Z1 C1 S0 V0; then CMP with r3=0x00, r4=0x05 → r3 unchanged 0x00, flags Z0 C0 S1 V0.
- wide ADD, r0:r1=0x00FF (r0=0xFF low), r2:r3=0x0001 → r0=0x00, r1=0x01, flags Z0 C0 S0 V0; reg_index sequence 0,0,0,0,1,1,1,1; done 9 cycles after transfer.
- Flags C=1, ADC r5=0xFF + r6=0x00 → r5=0x00, Z1 C1; then MOV r7 ← r5 → r7=0x00, flags unchanged; then XOR r5=0xF0 with r6=0x0F → r5=0xFF, C0 V0 S1.
- req_valid held high with back-to-back ops → req_ready low during RUN/DONE; second op starts exactly N+2 cycles after the first transfer; do_scan never asserted in IDLE or DONE.
- reset asserted at RUN step 2 of an ADD → outputs return to reset values asynchronously in the same cycle; no done; a subsequent request completes normally.

Source files
------------

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU stage: scans dst (port 1) and src (port 2) NSHIFT bits per cycle, LSB first,
// writes the result back through port 1 and keeps {V,S,C,Z} flags for special-register reads.
module serial_alu_sequencer #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2,
  parameter int LOG2_NR  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         op,
  input  logic               wide,
  input  logic [LOG2_NR-1:0] dst,
  input  logic [LOG2_NR-1:0] src,
  output logic [2:0]         bit_index,
  output logic [LOG2_NR-1:0] reg_index,
  output logic [LOG2_NR-1:0] reg_index2,
  output logic               do_scan,
  output logic               do_scan2,
  output logic [NSHIFT-1:0]  scan_in,
  output logic [NSHIFT-1:0]  scan_in2,
  input  logic [NSHIFT-1:0]  scan_out,
  input  logic [NSHIFT-1:0]  scan_out2,
  output logic [3:0]         flags,
  output logic               done
);

  localparam int STEPS = REG_BITS / NSHIFT;
  localparam int HALF_BIT = $clog2(STEPS);
  localparam logic [2:0] LAST_NARROW = 3'(STEPS - 1);
  localparam logic [2:0] LAST_WIDE = 3'(2 * STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MOV = 3'd0, OP_ADD = 3'd1, OP_ADC = 3'd2, OP_SUB = 3'd3,
    OP_CMP = 3'd4, OP_AND = 3'd5, OP_OR = 3'd6, OP_XOR = 3'd7
  } op_t;

  state_t state, state_nx;
  logic [2:0] k;
  op_t op_q;
  logic wide_q;
  logic [LOG2_NR-1:0] dst_q, src_q;
  logic carry_q, zacc_q;
  logic [3:0] flags_q, flags_nx;

  logic last_step, is_sub, is_logic, cin, cout, c_msb, z_now;
  logic [NSHIFT-1:0] b_eff, sum, result, low;
  logic [NSHIFT:0] full;

  assign last_step = (k == (wide_q ? LAST_WIDE : LAST_NARROW));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    do_scan   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = RUN;
      end
      RUN: begin
        do_scan = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign do_scan2 = do_scan;
  assign bit_index = k;
  assign reg_index = wide_q ? {dst_q[LOG2_NR-1:1], k[HALF_BIT]} : dst_q;
  assign reg_index2 = wide_q ? {src_q[LOG2_NR-1:1], k[HALF_BIT]} : src_q;
  assign scan_in2 = scan_out2;
  assign flags = flags_q;

  // One NSHIFT-bit slice of a + b' + c; the narrower add exposes the carry into the slice MSB for V.
  always_comb begin
    is_sub   = (op_q == OP_SUB) || (op_q == OP_CMP);
    is_logic = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
    b_eff    = is_sub ? ~scan_out2 : scan_out2;
    if (k == 3'd0) cin = (op_q == OP_ADC) ? flags_q[1] : is_sub;
    else           cin = carry_q;
    full  = {1'b0, scan_out} + {1'b0, b_eff} + {{NSHIFT{1'b0}}, cin};
    sum   = full[NSHIFT-1:0];
    cout  = full[NSHIFT];
    low   = {1'b0, scan_out[NSHIFT-2:0]} + {1'b0, b_eff[NSHIFT-2:0]} + {{(NSHIFT-1){1'b0}}, cin};
    c_msb = low[NSHIFT-1];
    case (op_q)
      OP_MOV:  result = scan_out2;
      OP_AND:  result = scan_out & scan_out2;
      OP_OR:   result = scan_out | scan_out2;
      OP_XOR:  result = scan_out ^ scan_out2;
      default: result = sum;
    endcase
    z_now = ((k == 3'd0) ? 1'b1 : zacc_q) & (result == '0);
    if (is_logic) flags_nx = {1'b0, result[NSHIFT-1], 1'b0, z_now};
    else          flags_nx = {c_msb ^ cout, result[NSHIFT-1], cout, z_now};
    if (state != RUN)        scan_in = '0;
    else if (op_q == OP_CMP) scan_in = scan_out;
    else                     scan_in = result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k       <= 3'd0;
      op_q    <= OP_MOV;
      wide_q  <= 1'b0;
      dst_q   <= '0;
      src_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
      flags_q <= 4'b0000;
    end else begin
      if (req_valid && req_ready) begin
        op_q   <= op_t'(op);
        wide_q <= wide;
        dst_q  <= dst;
        src_q  <= src;
        k      <= 3'd0;
      end
      if (state == RUN) begin
        k       <= last_step ? 3'd0 : k + 3'd1;
        carry_q <= cout;
        zacc_q  <= z_now;
        if (last_step && op_q != OP_MOV) flags_q <= flags_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Bench for serial_alu_sequencer: register-file environment, directed plan cases and
// randomized ops checked against a whole-word arithmetic reference model.
module tb_serial_alu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [2:0] op = 3'd0;
  logic wide = 1'b0;
  logic [3:0] dst = 4'd0, src = 4'd0;
  logic [2:0] bit_index;
  logic [3:0] reg_index, reg_index2;
  logic do_scan, do_scan2;
  logic [1:0] scan_in, scan_in2, scan_out, scan_out2;
  logic [3:0] flags;
  logic done;

  int checks = 0;
  int failures = 0;

  logic [7:0] regs [16];
  logic [7:0] m_regs [16];
  logic [3:0] m_flags = 4'b0000;
  logic load_en = 1'b0;
  logic [3:0] load_idx = 4'd0;
  logic [7:0] load_val = 8'd0;
  logic [3:0] idx_q [$];
  logic [3:0] idx2_q [$];

  serial_alu_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .wide(wide), .dst(dst), .src(src), .bit_index(bit_index),
    .reg_index(reg_index), .reg_index2(reg_index2), .do_scan(do_scan), .do_scan2(do_scan2),
    .scan_in(scan_in), .scan_in2(scan_in2), .scan_out(scan_out), .scan_out2(scan_out2),
    .flags(flags), .done(done)
  );

  always #5 clk = ~clk;

  // Register file: rotating scan registers, register 9 is the constant 1, port 1 wins on a clash.
  always_comb begin
    logic [7:0] t1, t2;
    t1 = (reg_index == 4'd9) ? (8'h01 >> {bit_index[1:0], 1'b0}) : regs[reg_index];
    t2 = (reg_index2 == 4'd9) ? (8'h01 >> {bit_index[1:0], 1'b0}) : regs[reg_index2];
    scan_out = t1[1:0];
    scan_out2 = t2[1:0];
  end

  always @(posedge clk) begin
    if (load_en) regs[load_idx] <= load_val;
    else begin
      if (do_scan && reg_index != 4'd9) regs[reg_index] <= {scan_in, regs[reg_index][7:2]};
      if (do_scan2 && reg_index2 != reg_index && reg_index2 != 4'd9)
        regs[reg_index2] <= {scan_in2, regs[reg_index2][7:2]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mrd(input logic [3:0] i);
    return (i == 4'd9) ? 8'h01 : m_regs[i];
  endfunction

  // Reference: whole-word unsigned/signed arithmetic on the addressed register(s).
  task automatic model_op(input logic [2:0] o, input logic w, input logic [3:0] d, input logic [3:0] s);
    logic [15:0] a, b, r, mask;
    logic [16:0] full;
    logic c, v, am, bm, rm;
    mask = w ? 16'hFFFF : 16'h00FF;
    a = w ? {mrd(d | 4'd1), mrd(d & 4'hE)} : {8'h00, mrd(d)};
    b = w ? {mrd(s | 4'd1), mrd(s & 4'hE)} : {8'h00, mrd(s)};
    full = 17'd0;
    case (o)
      3'd1: full = {1'b0, a} + {1'b0, b};
      3'd2: full = {1'b0, a} + {1'b0, b} + {16'd0, m_flags[1]};
      3'd3, 3'd4: full = {1'b0, a} + {1'b0, ~b & mask} + 17'd1;
      default: full = 17'd0;
    endcase
    case (o)
      3'd0: r = b;
      3'd5: r = a & b;
      3'd6: r = a | b;
      3'd7: r = a ^ b;
      default: r = full[15:0] & mask;
    endcase
    c  = w ? full[16] : full[8];
    am = w ? a[15] : a[7];
    bm = w ? b[15] : b[7];
    rm = w ? r[15] : r[7];
    if (o == 3'd3 || o == 3'd4) v = (am != bm) && (rm != am);
    else v = (am == bm) && (rm != am);
    if (o >= 3'd5) begin c = 1'b0; v = 1'b0; end
    if (o != 3'd0) m_flags = {v, rm, c, (r == 16'd0)};
    if (o != 3'd4) begin
      if (w) begin
        m_regs[d & 4'hE] = r[7:0];
        m_regs[d | 4'd1] = r[15:8];
      end else if (d != 4'd9) m_regs[d] = r[7:0];
    end
  endtask

  task automatic load(input logic [3:0] i, input logic [7:0] val);
    @(negedge clk);
    load_en = 1'b1; load_idx = i; load_val = val;
    @(posedge clk); #1;
    load_en = 1'b0;
    m_regs[i] = val;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++)
      if (i != 9) chk($sformatf("%s_r%0d", tag, i), {24'd0, regs[i]}, {24'd0, m_regs[i]});
    chk({tag, "_flags"}, {28'd0, flags}, {28'd0, m_flags});
  endtask

  // Launch one op, follow it to done, then check latency, state of handshake and results.
  task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                        input logic [3:0] d, input logic [3:0] s);
    int lat;
    int n;
    n = w ? 8 : 4;
    model_op(o, w, d, s);
    idx_q.delete(); idx2_q.delete();
    @(negedge clk);
    req_valid = 1'b1; op = o; wide = w; dst = d; src = s;
    chk({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) break;
      idx_q.push_back(reg_index);
      idx2_q.push_back(reg_index2);
    end
    chk({tag, "_latency"}, lat, n + 1);
    chk({tag, "_scan_in_done"}, {31'd0, do_scan}, 32'd0);
    chk({tag, "_ready_in_done"}, {31'd0, req_ready}, 32'd0);
    check_all(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int c;
    logic [2:0] o;
    logic w;
    logic [3:0] d, s;

    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_scan", {30'd0, do_scan, do_scan2}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_bit_index", {29'd0, bit_index}, 32'd0);
    for (int i = 0; i < 16; i++) load(4'(i), 8'($urandom));
    @(negedge clk); reset = 1'b0;

    // Plan case: ADD with signed overflow
    load(4'd1, 8'h7F); load(4'd2, 8'h01);
    run_op("add_ovf", 3'd1, 1'b0, 4'd1, 4'd2);
    chk("add_ovf_r1", {24'd0, regs[1]}, 32'h80);
    chk("add_ovf_r2", {24'd0, regs[2]}, 32'h01);
    chk("add_ovf_flags", {28'd0, flags}, 32'b1100);

    // Plan case: SUB to zero, then CMP with borrow
    load(4'd3, 8'h05); load(4'd4, 8'h05);
    run_op("sub_zero", 3'd3, 1'b0, 4'd3, 4'd4);
    chk("sub_zero_r3", {24'd0, regs[3]}, 32'h00);
    chk("sub_zero_flags", {28'd0, flags}, 32'b0011);
    run_op("cmp_borrow", 3'd4, 1'b0, 4'd3, 4'd4);
    chk("cmp_borrow_r3", {24'd0, regs[3]}, 32'h00);
    chk("cmp_borrow_flags", {28'd0, flags}, 32'b0100);

    // Plan case: 16-bit ADD across a register pair
    load(4'd0, 8'hFF); load(4'd1, 8'h00); load(4'd2, 8'h01); load(4'd3, 8'h00);
    run_op("wide_add", 3'd1, 1'b1, 4'd0, 4'd2);
    chk("wide_add_r0", {24'd0, regs[0]}, 32'h00);
    chk("wide_add_r1", {24'd0, regs[1]}, 32'h01);
    chk("wide_add_flags", {28'd0, flags}, 32'b0000);
    chk("wide_add_steps", idx_q.size(), 8);
    for (int i = 0; i < idx_q.size(); i++) begin
      chk($sformatf("wide_add_idx%0d", i), {28'd0, idx_q[i]}, (i < 4) ? 32'd0 : 32'd1);
      chk($sformatf("wide_add_idx2_%0d", i), {28'd0, idx2_q[i]}, (i < 4) ? 32'd2 : 32'd3);
    end

    // Plan case: ADC consuming C, MOV leaving flags, XOR clearing C/V
    load(4'd5, 8'hFF); load(4'd6, 8'h00);
    run_op("cmp_setc", 3'd4, 1'b0, 4'd6, 4'd6);
    chk("cmp_setc_flags", {28'd0, flags}, 32'b0011);
    run_op("adc", 3'd2, 1'b0, 4'd5, 4'd6);
    chk("adc_r5", {24'd0, regs[5]}, 32'h00);
    chk("adc_flags", {28'd0, flags}, 32'b0011);
    load(4'd7, 8'h5A);
    run_op("mov", 3'd0, 1'b0, 4'd7, 4'd5);
    chk("mov_r7", {24'd0, regs[7]}, 32'h00);
    chk("mov_flags", {28'd0, flags}, 32'b0011);
    load(4'd5, 8'hF0); load(4'd6, 8'h0F);
    run_op("xor", 3'd7, 1'b0, 4'd5, 4'd6);
    chk("xor_r5", {24'd0, regs[5]}, 32'hFF);
    chk("xor_flags", {28'd0, flags}, 32'b0100);

    // Immediate-one via constant register 9
    load(4'd8, 8'h41);
    run_op("add_imm1", 3'd1, 1'b0, 4'd8, 4'd9);
    chk("add_imm1_r8", {24'd0, regs[8]}, 32'h42);

    // Back-to-back with req_valid held; fields changed mid-run must be ignored until IDLE
    load(4'd1, 8'h10); load(4'd2, 8'h03); load(4'd3, 8'h20); load(4'd4, 8'h07);
    model_op(3'd1, 1'b0, 4'd1, 4'd2);
    model_op(3'd3, 1'b0, 4'd3, 4'd4);
    @(negedge clk);
    req_valid = 1'b1; op = 3'd1; wide = 1'b0; dst = 4'd1; src = 4'd2;
    @(posedge clk); #1;
    op = 3'd3; dst = 4'd3; src = 4'd4;
    for (c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", c), {31'd0, req_ready}, (c == 6) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_scan_c%0d", c), {31'd0, do_scan}, (c <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_done_c%0d", c), {31'd0, done}, (c == 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_run", {31'd0, do_scan}, 32'd1);
    chk("b2b_second_idx", {28'd0, reg_index}, 32'd3);
    chk("b2b_second_step", {29'd0, bit_index}, 32'd0);
    c = 0;
    while (!done && c < 20) begin @(negedge clk); c++; end
    chk("b2b_second_lat", c, 4);
    check_all("b2b");

    // Reset in the middle of an ADD
    @(negedge clk);
    load(4'd1, 8'h33); load(4'd2, 8'h11);
    @(negedge clk);
    req_valid = 1'b1; op = 3'd1; wide = 1'b0; dst = 4'd1; src = 4'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (bit_index != 3'd2 && c < 10);
    chk("rst_mid_reach_step2", {31'd0, (bit_index == 3'd2 && do_scan)}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_scan", {30'd0, do_scan, do_scan2}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_flags", {28'd0, flags}, 32'd0);
    chk("rst_mid_bit_index", {29'd0, bit_index}, 32'd0);
    c = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (done) c++; end
    chk("rst_mid_no_done", c, 0);
    reset = 1'b0;
    m_flags = 4'b0000;
    load(4'd1, 8'h33); load(4'd2, 8'h11);
    run_op("after_rst", 3'd1, 1'b0, 4'd1, 4'd2);
    chk("after_rst_r1", {24'd0, regs[1]}, 32'h44);

    // Randomized ops against the reference model
    for (int it = 0; it < 40; it++) begin
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      if (w) begin
        d = 4'($urandom_range(0, 7));
        s = 4'($urandom_range(0, 7));
      end else begin
        d = 4'($urandom_range(0, 11));
        s = 4'($urandom_range(0, 11));
      end
      load(4'($urandom_range(0, 11)), 8'($urandom));
      run_op($sformatf("rnd%0d", it), o, w, d, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
